rx_fifo: RTL and testbench

RX_FIFO -- requirements
Module: rx_fifo

---
 rtl/uart_pkg.sv | 13 +
 rtl/fifo_mem.sv | 29 ++
 rtl/rx_fifo.sv | 139 +++++++++++++
 tb/tb_rx_fifo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: default RX FIFO geometry and the drop-counter width.
package uart_pkg;

  localparam int unsigned RxDataBits  = 8;
  localparam int unsigned RxFifoWidth = 4;
  localparam int unsigned DropCntBits = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DropCntBits-1:0] sat_inc(input logic [DropCntBits-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for rx_fifo: one write port, one registered read port, no reset.
module fifo_mem #(
  parameter int unsigned DataBits = 8,
  parameter int unsigned AddrBits = 4
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [AddrBits-1:0] waddr_i,
  input  logic [DataBits-1:0] wdata_i,
  input  logic                re_i,
  input  logic [AddrBits-1:0] raddr_i,
  output logic [DataBits-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrBits;

  logic [DataBits-1:0] mem_q [Depth];

  // Read returns the pre-write contents when both ports hit the same slot.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/rx_fifo.sv
// Receive FIFO with occupancy flags, sticky overflow, flush and BIST freeze.
// Define RX_FIFO_DROP_CNT_EN to add the saturating Drop_Count output.
module rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = RxDataBits,
  parameter int unsigned FIFO_WIDTH  = RxFifoWidth,
  parameter int unsigned HALF_THRESH = 2 ** (FIFO_WIDTH - 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] Rx_Data,
  input  logic                 Data_Rdy,
  input  logic                 Pop_Data,
  input  logic                 Flush,
  input  logic                 BIST_Mode,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Data_Valid,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 FIFO_Half,
  output logic                 FIFO_Overflow,
`ifdef RX_FIFO_DROP_CNT_EN
  output logic [DropCntBits-1:0] Drop_Count,
`endif
  output logic [FIFO_WIDTH:0]  FIFO_Count
);

  localparam logic [FIFO_WIDTH:0] DepthCnt = {1'b1, {FIFO_WIDTH{1'b0}}};
  localparam logic [FIFO_WIDTH:0] HalfCnt  = (FIFO_WIDTH + 1)'(HALF_THRESH);

  logic [FIFO_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  valid_q;
  logic                  out_zero_q;
  logic [DATA_BITS-1:0]  mem_rdata;

  logic run;
  logic pop_acc;
  logic push_acc;
  logic drop;

  assign run      = ~Flush & ~BIST_Mode;
  assign pop_acc  = run & Pop_Data & (count_q != '0);
  assign push_acc = run & Data_Rdy & ((count_q != DepthCnt) | pop_acc);
  assign drop     = run & Data_Rdy & ~push_acc;

  fifo_mem #(
    .DataBits(DATA_BITS),
    .AddrBits(FIFO_WIDTH)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (push_acc & ~rst),
    .waddr_i(wr_ptr_q),
    .wdata_i(Rx_Data),
    .re_i   (pop_acc & ~rst),
    .raddr_i(rd_ptr_q),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // A drop in the same cycle as a clearing pop leaves the flag set.
      if (drop) begin
        ovf_d = 1'b1;
      end else if (pop_acc) begin
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      out_zero_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      valid_q  <= pop_acc;
      if (pop_acc) begin
        out_zero_q <= 1'b0;
      end
    end
  end

  // The storage read register has no reset, so mask it to zero until the first pop.
  assign Data_Out      = out_zero_q ? '0 : mem_rdata;
  assign Data_Valid    = valid_q;
  assign FIFO_Count    = count_q;
  assign FIFO_Overflow = ovf_q;
  assign FIFO_Empty    = (count_q == '0);
  assign FIFO_Full     = (count_q == DepthCnt);
  assign FIFO_Half     = (count_q >= HalfCnt);

`ifdef RX_FIFO_DROP_CNT_EN
  logic [DropCntBits-1:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      drop_cnt_q <= sat_inc(drop_cnt_q);
    end
  end

  assign Drop_Count = drop_cnt_q;
`else
  // Build without the drop counter: overflow is reported only through FIFO_Overflow.
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo (DATA_BITS=8, FIFO_WIDTH=2, HALF_THRESH=2) with a queue model.
module tb_rx_fifo;

  localparam int DW    = 8;
  localparam int FW    = 2;
  localparam int HT    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] Rx_Data = '0;
  logic          Data_Rdy = 1'b0;
  logic          Pop_Data = 1'b0;
  logic          Flush = 1'b0;
  logic          BIST_Mode = 1'b0;
  logic [DW-1:0] Data_Out;
  logic          Data_Valid;
  logic          FIFO_Empty;
  logic          FIFO_Full;
  logic          FIFO_Half;
  logic          FIFO_Overflow;
  logic [FW:0]   FIFO_Count;
`ifdef RX_FIFO_DROP_CNT_EN
  logic [7:0]    Drop_Count;
`endif

  always #5 clk = ~clk;

  rx_fifo #(
    .DATA_BITS  (DW),
    .FIFO_WIDTH (FW),
    .HALF_THRESH(HT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Rx_Data      (Rx_Data),
    .Data_Rdy     (Data_Rdy),
    .Pop_Data     (Pop_Data),
    .Flush        (Flush),
    .BIST_Mode    (BIST_Mode),
    .Data_Out     (Data_Out),
    .Data_Valid   (Data_Valid),
    .FIFO_Empty   (FIFO_Empty),
    .FIFO_Full    (FIFO_Full),
    .FIFO_Half    (FIFO_Half),
    .FIFO_Overflow(FIFO_Overflow),
`ifdef RX_FIFO_DROP_CNT_EN
    .Drop_Count   (Drop_Count),
`endif
    .FIFO_Count   (FIFO_Count)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: contents as a queue plus the visible registered outputs.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_dv   = 1'b0;
  bit            m_ovf  = 1'b0;
  int            m_dc   = 0;

  // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
  task automatic step(input bit r, input bit rdy, input logic [DW-1:0] d, input bit pop,
                      input bit fl, input bit bi);
    bit pop_ok, push_ok;
    rst = r; Data_Rdy = rdy; Rx_Data = d; Pop_Data = pop; Flush = fl; BIST_Mode = bi;
    if (r) begin
      mq.delete(); m_dout = '0; m_dv = 0; m_ovf = 0; m_dc = 0;
    end else if (fl) begin
      mq.delete(); m_dv = 0; m_ovf = 0; m_dc = 0;
    end else if (bi) begin
      m_dv = 0;
    end else begin
      pop_ok  = pop && (mq.size() > 0);
      push_ok = rdy && ((mq.size() < DEPTH) || pop_ok);
      m_dv = pop_ok;
      if (pop_ok) begin m_dout = mq.pop_front(); m_ovf = 0; end
      if (push_ok) mq.push_back(d);
      if (rdy && !push_ok) begin m_ovf = 1; if (m_dc < 255) m_dc++; end
    end
    @(posedge clk); #1;
    rst = 0; Data_Rdy = 0; Pop_Data = 0; Flush = 0; BIST_Mode = 0;
  endtask

  task automatic push(input logic [DW-1:0] d); step(0, 1, d, 0, 0, 0); endtask
  task automatic pop();                        step(0, 0, '0, 1, 0, 0); endtask
  task automatic idle();                       step(0, 0, '0, 0, 0, 0); endtask

  task automatic test_reset();
    step(1, 1, 8'hAA, 1, 1, 1);
    step(1, 0, '0, 0, 0, 0);
    checks++; if (FIFO_Count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", FIFO_Count); end
    checks++; if (FIFO_Empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", FIFO_Empty); end
    checks++; if (FIFO_Full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", FIFO_Full); end
    checks++; if (FIFO_Half !== 1'b0) begin errors++; $display("FAIL reset_half got=%b exp=0", FIFO_Half); end
    checks++; if (FIFO_Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", FIFO_Overflow); end
    checks++; if (Data_Out !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", Data_Out); end
    checks++; if (Data_Valid !== 1'b0) begin errors++; $display("FAIL reset_dvalid got=%b exp=0", Data_Valid); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    step(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 3; i++) push(exp_d[i]);
    checks++; if (FIFO_Count !== 3'd3) begin errors++; $display("FAIL basic_count got=%0d exp=3", FIFO_Count); end
    checks++; if (FIFO_Half !== 1'b1) begin errors++; $display("FAIL basic_half got=%b exp=1", FIFO_Half); end
    checks++; if (FIFO_Empty !== 1'b0) begin errors++; $display("FAIL basic_empty got=%b exp=0", FIFO_Empty); end
    for (int i = 0; i < 3; i++) begin
      pop();
      checks++; if (Data_Out !== exp_d[i]) begin errors++; $display("FAIL basic_pop%0d_dout got=%h exp=%h", i, Data_Out, exp_d[i]); end
      checks++; if (Data_Valid !== 1'b1) begin errors++; $display("FAIL basic_pop%0d_dvalid got=%b exp=1", i, Data_Valid); end
      idle();
      checks++; if (Data_Valid !== 1'b0) begin errors++; $display("FAIL basic_pulse%0d got=%b exp=0", i, Data_Valid); end
      checks++; if (Data_Out !== exp_d[i]) begin errors++; $display("FAIL basic_hold%0d got=%h exp=%h", i, Data_Out, exp_d[i]); end
    end
    checks++; if (FIFO_Empty !== 1'b1) begin errors++; $display("FAIL basic_empty_end got=%b exp=1", FIFO_Empty); end
    // Pop while empty must be ignored.
    pop();
    checks++; if (Data_Valid !== 1'b0 || FIFO_Count !== 3'd0) begin
      errors++; $display("FAIL basic_empty_pop dvalid=%b count=%0d exp dvalid=0 count=0", Data_Valid, FIFO_Count);
    end
  endtask

  task automatic test_overflow();
    step(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) push(8'hA1 + 8'(i));
    checks++; if (FIFO_Full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", FIFO_Full); end
    checks++; if (FIFO_Overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got=%b exp=0", FIFO_Overflow); end
    push(8'h55);
    checks++; if (FIFO_Overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", FIFO_Overflow); end
    checks++; if (FIFO_Count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", FIFO_Count); end
    checks++; if (FIFO_Full !== 1'b1) begin errors++; $display("FAIL ovf_full2 got=%b exp=1", FIFO_Full); end
`ifdef RX_FIFO_DROP_CNT_EN
    checks++; if (Drop_Count !== 8'd1) begin errors++; $display("FAIL ovf_dropcnt got=%0d exp=1", Drop_Count); end
`endif
    idle();
    checks++; if (FIFO_Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", FIFO_Overflow); end
    pop();
    checks++; if (Data_Out !== 8'hA1) begin errors++; $display("FAIL ovf_first got=%h exp=a1", Data_Out); end
    checks++; if (FIFO_Overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", FIFO_Overflow); end
    checks++; if (FIFO_Count !== 3'd3) begin errors++; $display("FAIL ovf_count_after got=%0d exp=3", FIFO_Count); end
  endtask

  task automatic test_full_push_pop();
    step(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) push(8'hB1 + 8'(i));
    step(0, 1, 8'h66, 1, 0, 0);
    checks++; if (FIFO_Count !== 3'd4) begin errors++; $display("FAIL fpp_count got=%0d exp=4", FIFO_Count); end
    checks++; if (FIFO_Overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got=%b exp=0", FIFO_Overflow); end
    checks++; if (Data_Out !== 8'hB1) begin errors++; $display("FAIL fpp_first got=%h exp=b1", Data_Out); end
    for (int i = 1; i < DEPTH; i++) begin
      pop();
      checks++; if (Data_Out !== 8'hB1 + 8'(i)) begin errors++; $display("FAIL fpp_pop%0d got=%h exp=%h", i, Data_Out, 8'hB1 + 8'(i)); end
    end
    pop();
    checks++; if (Data_Out !== 8'h66) begin errors++; $display("FAIL fpp_new got=%h exp=66", Data_Out); end
    checks++; if (FIFO_Empty !== 1'b1) begin errors++; $display("FAIL fpp_empty got=%b exp=1", FIFO_Empty); end
  endtask

  task automatic test_wrap();
    step(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      push(8'(i));
      checks++; if (FIFO_Count !== 3'd1) begin errors++; $display("FAIL wrap_count%0d got=%0d exp=1", i, FIFO_Count); end
      pop();
      checks++; if (Data_Out !== 8'(i) || Data_Valid !== 1'b1) begin
        errors++; $display("FAIL wrap_out%0d got=%h/%b exp=%h/1", i, Data_Out, Data_Valid, 8'(i));
      end
    end
  endtask

  task automatic test_bist_flush();
    step(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 4; i++) push(8'hC1 + 8'(i));
    pop();
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'hEE, 1, 0, 1);
      checks++; if (FIFO_Count !== 3'd3 || Data_Out !== 8'hC1 || Data_Valid !== 1'b0) begin
        errors++; $display("FAIL bist%0d count=%0d dout=%h dv=%b exp 3/c1/0", i, FIFO_Count, Data_Out, Data_Valid);
      end
    end
    step(0, 1, 8'hEE, 1, 1, 1);
    checks++; if (FIFO_Count !== 3'd0 || FIFO_Empty !== 1'b1) begin
      errors++; $display("FAIL flush_count count=%0d empty=%b exp 0/1", FIFO_Count, FIFO_Empty);
    end
    checks++; if (Data_Out !== 8'hC1 || Data_Valid !== 1'b0) begin
      errors++; $display("FAIL flush_dout dout=%h dv=%b exp c1/0", Data_Out, Data_Valid);
    end
    push(8'hD1);
    push(8'hD2);
    step(1, 1, 8'h77, 1, 0, 0);
    checks++; if (FIFO_Count !== 3'd0 || Data_Out !== 8'h00 || Data_Valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid count=%0d dout=%h dv=%b exp 0/00/0", FIFO_Count, Data_Out, Data_Valid);
    end
    pop();
    checks++; if (FIFO_Empty !== 1'b1 || Data_Valid !== 1'b0) begin
      errors++; $display("FAIL rst_nowrite empty=%b dv=%b exp 1/0", FIFO_Empty, Data_Valid);
    end
  endtask

  task automatic test_random();
    bit r, rdy, pp, fl, bi;
    int sz;
    step(1, 0, '0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 99) < 1);
      fl  = ($urandom_range(0, 99) < 3);
      bi  = ($urandom_range(0, 99) < 6);
      rdy = ($urandom_range(0, 99) < 60);
      pp  = ($urandom_range(0, 99) < 50);
      step(r, rdy, 8'($urandom), pp, fl, bi);
      sz = mq.size();
      checks++;
      if (FIFO_Count !== (FW + 1)'(sz) || Data_Out !== m_dout || Data_Valid !== m_dv ||
          FIFO_Overflow !== m_ovf || FIFO_Empty !== (sz == 0) || FIFO_Full !== (sz == DEPTH) ||
          FIFO_Half !== (sz >= HT)) begin
        errors++;
        $display("FAIL rand%0d cnt=%0d dout=%h dv=%b ovf=%b e/f/h=%b%b%b exp cnt=%0d dout=%h dv=%b ovf=%b",
                 n, FIFO_Count, Data_Out, Data_Valid, FIFO_Overflow, FIFO_Empty, FIFO_Full,
                 FIFO_Half, sz, m_dout, m_dv, m_ovf);
      end
`ifdef RX_FIFO_DROP_CNT_EN
      checks++; if (Drop_Count !== 8'(m_dc)) begin errors++; $display("FAIL rand%0d_dropcnt got=%0d exp=%0d", n, Drop_Count, m_dc); end
`endif
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_bist_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
